// File: rtl/mac_feeder_pkg.sv
// Shared types and latency constants for the MAC dot-product feeder.
// The latencies describe the memories and the MAC instance this block drives.
package mac_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_LATCH   = 3'd3,
    S_CAPTURE = 3'd4,
    S_HOLD    = 3'd5
  } mac_state_e;

  localparam int MEM_RD_LAT  = 1;
  localparam int DRAIN_CYC   = 2;
  localparam int MAC_OUT_LAT = 1;

endpackage

// File: rtl/mac_operand_pipe.sv
// Registered operand stage: aligns memory read data with the delayed read
// strobe and presents zeroed operands whenever the enable is low.
module mac_operand_pipe
  import mac_feeder_pkg::*;
#(
  parameter int I_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic signed [I_W-1:0] w_data,
  input  logic signed [I_W-1:0] x_data,
  output logic signed [I_W-1:0] mac_a,
  output logic signed [I_W-1:0] mac_b,
  output logic                  mac_en
);

  // Strobe delay line matching the memory read latency.
  logic [MEM_RD_LAT-1:0] rd_dly;
  logic                  data_vld;

  assign data_vld = rd_dly[MEM_RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dly <= '0;
      mac_a  <= '0;
      mac_b  <= '0;
      mac_en <= 1'b0;
    end else begin
      rd_dly <= (rd_dly << 1) | MEM_RD_LAT'(rd);
      mac_a  <= data_vld ? w_data : '0;
      mac_b  <= data_vld ? x_data : '0;
      mac_en <= data_vld;
    end
  end

endmodule

// File: rtl/mac_dot_feeder.sv
// Sequencer that streams one dot product from two memories into a MAC and
// returns the captured MAC result on a valid/ready port.
module mac_dot_feeder
  import mac_feeder_pkg::*;
#(
  parameter int I_W    = 32,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  input  logic [ADDR_W-1:0]       w_base,
  input  logic [ADDR_W-1:0]       x_base,
  output logic                    w_rd,
  output logic                    x_rd,
  output logic [ADDR_W-1:0]       w_addr,
  output logic [ADDR_W-1:0]       x_addr,
  input  logic signed [I_W-1:0]   w_data,
  input  logic signed [I_W-1:0]   x_data,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    mac_out_en,
  output logic signed [I_W-1:0]   mac_A,
  output logic signed [I_W-1:0]   mac_B,
  input  logic signed [2*I_W+1:0] mac_Y,
  output logic signed [2*I_W+1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output mac_state_e              dbg_state
);

  // Handshake: a result transfers on any rising edge where res_valid and
  // res_ready are both high; res_valid and res_data stay fixed until then.

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  mac_state_e        state, state_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     len_q;
  logic [ADDR_W-1:0] w_base_q, x_base_q;
  logic              rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      res_data <= '0;
    end else begin
      state <= state_d;
      // One counter serves every timed state; it restarts on each transition.
      cnt   <= (state_d != state) ? '0 : cnt + ONE;
      if (state == S_IDLE && start) begin
        len_q    <= len;
        w_base_q <= w_base;
        x_base_q <= x_base;
      end
      if (state == S_CAPTURE) res_data <= mac_Y;
    end
  end

  always_comb begin
    state_d    = state;
    rd         = 1'b0;
    mac_clr    = 1'b0;
    mac_out_en = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && len != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        rd      = 1'b1;
        mac_clr = (cnt == '0);
        if (cnt == len_q - ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == CW'(DRAIN_CYC - 1)) state_d = S_LATCH;
      end
      S_LATCH: begin
        mac_out_en = 1'b1;
        if (cnt == CW'(MAC_OUT_LAT - 1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Addresses wrap naturally in ADDR_W bits.
  assign w_rd      = rd;
  assign x_rd      = rd;
  assign w_addr    = rd ? w_base_q + cnt[ADDR_W-1:0] : '0;
  assign x_addr    = rd ? x_base_q + cnt[ADDR_W-1:0] : '0;
  assign res_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  mac_operand_pipe #(
    .I_W(I_W)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .rd     (rd),
    .w_data (w_data),
    .x_data (x_data),
    .mac_a  (mac_A),
    .mac_b  (mac_B),
    .mac_en (mac_en)
  );

endmodule

// File: tb/tb_mac_dot_feeder.sv
// Bench for mac_dot_feeder: behavioural memories and MAC around the DUT,
// table-driven runs plus hand-written corner sequences and a result scoreboard.
module tb_mac_dot_feeder;
  import mac_feeder_pkg::*;

  localparam int I_W    = 32;
  localparam int ADDR_W = 10;
  localparam int YW     = 2 * I_W + 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [ADDR_W:0]        len = '0;
  logic [ADDR_W-1:0]      w_base = '0;
  logic [ADDR_W-1:0]      x_base = '0;
  logic                   w_rd, x_rd;
  logic [ADDR_W-1:0]      w_addr, x_addr;
  logic signed [I_W-1:0]  w_data = '0;
  logic signed [I_W-1:0]  x_data = '0;
  logic                   mac_clr, mac_en, mac_out_en;
  logic signed [I_W-1:0]  mac_A, mac_B;
  logic signed [YW-1:0]   mac_Y = '0;
  logic signed [YW-1:0]   res_data;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic                   busy;
  mac_state_e             dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_dot_feeder #(.I_W(I_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .w_base(w_base), .x_base(x_base),
    .w_rd(w_rd), .x_rd(x_rd), .w_addr(w_addr), .x_addr(x_addr),
    .w_data(w_data), .x_data(x_data),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_out_en(mac_out_en),
    .mac_A(mac_A), .mac_B(mac_B), .mac_Y(mac_Y),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  logic signed [I_W-1:0] w_mem [DEPTH];
  logic signed [I_W-1:0] x_mem [DEPTH];
  logic signed [YW-1:0]  acc = '0;

  always @(posedge clk) begin
    if (w_rd) w_data <= w_mem[w_addr];
    if (x_rd) x_data <= x_mem[x_addr];
  end

  always @(posedge clk) begin
    if (mac_clr)     acc <= '0;
    else if (mac_en) acc <= acc + mac_A * mac_B;
    if (mac_out_en)  mac_Y <= acc;
  end

  // ---------------- scoreboard ----------------
  logic [YW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [YW-1:0] ref_dot(input int n, input int wb, input int xb);
    logic signed [YW-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      s = s + w_mem[(wb + i) % DEPTH] * x_mem[(xb + i) % DEPTH];
    return s;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int                         n;
    int                         wb;
    int                         xb;
    logic [3:0][I_W-1:0]        w;
    logic [3:0][I_W-1:0]        x;
    logic signed [YW-1:0]       exp;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input int n, input int wb, input int xb,
                              input logic [I_W-1:0] w0, input logic [I_W-1:0] w1,
                              input logic [I_W-1:0] w2, input logic [I_W-1:0] w3,
                              input logic [I_W-1:0] x0, input logic [I_W-1:0] x1,
                              input logic [I_W-1:0] x2, input logic [I_W-1:0] x3,
                              input logic signed [YW-1:0] exp);
    vec_t v;
    v.n = n; v.wb = wb; v.xb = xb;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.exp = exp;
    return v;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      w_mem[(v.wb + i) % DEPTH] = v.w[i];
      x_mem[(v.xb + i) % DEPTH] = v.x[i];
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; the start cycle is "cycle 0" of the run.
  task automatic do_run(input int n, input int wb, input int xb, input int rdly,
                        input logic [YW-1:0] exp, input bit poke);
    int c;
    bit clr_ok, en_ok, ops_ok, oen_ok, addr_ok, busy_ok, stable_ok;
    logic [YW-1:0] held;
    exp_q.push_back(exp);
    start = 1'b1; len = (ADDR_W+1)'(n);
    w_base = ADDR_W'(wb); x_base = ADDR_W'(xb);
    @(posedge clk); @(negedge clk);
    start = 1'b0; len = '0;
    clr_ok = 1; en_ok = 1; ops_ok = 1; oen_ok = 1; addr_ok = 1; busy_ok = 1; stable_ok = 1;
    c = 1;
    while (!res_valid && c < n + 12) begin
      if (mac_clr !== (c == 1)) clr_ok = 0;
      if (mac_en !== (c >= 3 && c <= n + 2)) en_ok = 0;
      if (mac_en === 1'b1) begin
        if (mac_A !== w_mem[(wb + c - 3) % DEPTH] || mac_B !== x_mem[(xb + c - 3) % DEPTH]) ops_ok = 0;
      end else if (mac_A !== '0 || mac_B !== '0) ops_ok = 0;
      if (mac_out_en !== (c == n + 3)) oen_ok = 0;
      if (w_rd !== (c <= n) || x_rd !== (c <= n)) addr_ok = 0;
      if (c <= n && (w_addr !== ADDR_W'((wb + c - 1) % DEPTH) ||
                     x_addr !== ADDR_W'((xb + c - 1) % DEPTH))) addr_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      @(negedge clk);
      c++;
    end
    check("clr_pulse", YW'(clr_ok), YW'(1));
    check("en_window", YW'(en_ok), YW'(1));
    check("operands", YW'(ops_ok), YW'(1));
    check("out_en_cycle", YW'(oen_ok), YW'(1));
    check("rd_addr_seq", YW'(addr_ok), YW'(1));
    check("busy_high", YW'(busy_ok), YW'(1));
    check("valid_latency", YW'(c), YW'(n + 5));
    if (res_valid !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    held = res_data;
    for (int d = 0; d < rdly; d++) begin
      if (poke && d == 2) begin start = 1'b1; len = (ADDR_W+1)'(2); end
      @(negedge clk);
      start = 1'b0; len = '0;
      if (res_valid !== 1'b1 || res_data !== held || busy !== 1'b1) stable_ok = 0;
    end
    if (rdly > 0) check("hold_stable", YW'(stable_ok), YW'(1));
    res_ready = 1'b1;
    check("result", res_data, exp_q.pop_front());
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check("busy_fall", YW'(busy), YW'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, wb, xb;
    vecs[0] = mk(4, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 70);
    vecs[1] = mk(2, 100, 200, -3, 7, 0, 0, 4, -2, 0, 0, -26);
    vecs[2] = mk(4, 1022, 0, 1, -1, 5, 9, 2, 3, 4, 5, 64);
    vecs[3] = mk(1, 500, 501, -7, 0, 0, 0, 6, 0, 0, 0, -42);
    vecs[4] = mk(2, 10, 20, 32'h7fffffff, 32'h7fffffff, 0, 0,
                 32'h7fffffff, 32'h7fffffff, 0, 0, 66'sh0_7FFF_FFFE_0000_0002);
    vecs[5] = mk(2, 30, 40, 32'h80000000, 32'h80000000, 0, 0,
                 32'h80000000, 32'h80000000, 0, 0, 66'sh0_8000_0000_0000_0000);
    for (int i = 0; i < DEPTH; i++) begin
      w_mem[i] = I_W'(i + 1);
      x_mem[i] = I_W'(3 * i - 5);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          YW'({w_rd, x_rd, w_addr, x_addr, mac_clr, mac_en, mac_out_en, res_valid, busy}), YW'(0));
    check("reset_res_data", res_data, YW'(0));
    check("reset_state", YW'(dbg_state), YW'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Table runs, issued back-to-back (each start lands in the cycle after the handshake)
    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      do_run(vecs[i].n, vecs[i].wb, vecs[i].xb, 0, vecs[i].exp, 1'b0);
    end

    // Backpressure with a start pulse while holding
    load_vec(vecs[0]);
    do_run(4, 0, 0, 10, 70, 1'b1);
    repeat (3) @(negedge clk);
    check("held_start_ignored", YW'(busy), YW'(0));

    // Zero-length start is ignored
    start = 1'b1; len = '0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("len0_busy", YW'(busy), YW'(0));

    // Reset mid-run, then a fresh run must not see leftover accumulation
    for (int i = 0; i < 8; i++) begin w_mem[i] = I_W'(i + 3); x_mem[i] = I_W'(9 - i); end
    start = 1'b1; len = (ADDR_W+1)'(8); w_base = '0; x_base = '0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs",
          YW'({w_rd, x_rd, w_addr, x_addr, mac_clr, mac_en, mac_out_en, res_valid, busy}), YW'(0));
    check("midrst_operands", YW'({mac_A, mac_B}), YW'(0));
    check("midrst_res_data", res_data, YW'(0));
    @(negedge clk);
    check("midrst_inflight", YW'({mac_en, mac_A, mac_B}), YW'(0));
    w_mem[50] = 2; w_mem[51] = 2; x_mem[60] = 3; x_mem[61] = 3;
    do_run(2, 50, 60, 0, 12, 1'b0);

    // Randomised runs against the reference model
    for (int r = 0; r < 4; r++) begin
      n  = $urandom_range(1, 16);
      wb = $urandom_range(0, DEPTH - 1);
      xb = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < n; i++) begin
        w_mem[(wb + i) % DEPTH] = I_W'($urandom);
        x_mem[(xb + i) % DEPTH] = I_W'($urandom);
      end
      do_run(n, wb, xb, $urandom_range(0, 3), ref_dot(n, wb, xb), 1'b0);
    end

    // Maximum length
    for (int i = 0; i < DEPTH; i++) begin
      w_mem[i] = I_W'($urandom_range(0, 2000)) - I_W'(1000);
      x_mem[i] = I_W'($urandom);
    end
    do_run(DEPTH, 7, 900, 1, ref_dot(DEPTH, 7, 900), 1'b0);

    check("sb_empty", YW'(exp_q.size()), YW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
